// File: rtl/iir_i2s_dac_out.sv
// I2S DAC output stage: converts the IIR filter's signed sample to PCM
// (shift/round/saturate) and serializes it MSB-first on both channels.
//
// Ports:
//   clk            system clock, rising edge
//   i_rst          synchronous active-high reset
//   i_valid        filter path enable; low flushes the block
//   lrclk_negedge  strobe: left word start, captures a new sample
//   lrclk_posedge  strobe: right word start, replays the held sample
//   bclk_negedge   strobe: advance one serial bit
//   audio_in       signed IN_W-bit sample from the IIR stage
//   o_dacdat       serial DAC data
//   o_busy         high while a word is being shifted
//   o_clip         one-cycle pulse when a captured sample saturated
//   o_clip_cnt     saturating count of clip events
module iir_i2s_dac_out #(
  parameter int IN_W  = 21,
  parameter int OUT_W = 16,
  parameter int SHIFT = 0,
  parameter int ROUND = 0
) (
  input  logic            clk,
  input  logic            i_rst,
  input  logic            i_valid,
  input  logic            lrclk_negedge,
  input  logic            lrclk_posedge,
  input  logic            bclk_negedge,
  input  logic [IN_W-1:0] audio_in,
  output logic            o_dacdat,
  output logic            o_busy,
  output logic            o_clip,
  output logic [15:0]     o_clip_cnt
);

  localparam int CW = $clog2(OUT_W + 1);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_SHIFT = 1'b1;

  localparam int RSH = (SHIFT > 0) ? SHIFT - 1 : 0;
  localparam logic [IN_W:0] RND =
    (ROUND != 0 && SHIFT > 0) ? ((IN_W+1)'(1) << RSH) : '0;

  localparam int SMAX_I = (1 << (OUT_W - 1)) - 1;
  localparam int SMIN_I = -(1 << (OUT_W - 1));
  localparam logic signed [IN_W:0] SMAX = (IN_W+1)'(SMAX_I);
  localparam logic signed [IN_W:0] SMIN = (IN_W+1)'(SMIN_I);

  localparam logic [OUT_W-1:0] PCM_MAX = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W-1:0] PCM_MIN = {1'b1, {(OUT_W-1){1'b0}}};

  // ---------------- conversion ----------------
  // One extra bit of headroom so the rounding add cannot wrap.
  logic signed [IN_W:0] t_s;
  logic signed [IN_W:0] s_s;
  logic [OUT_W-1:0]     pcm;
  logic                 clip_f;

  always_comb begin
    t_s = $signed({audio_in[IN_W-1], audio_in}) + $signed(RND);
    s_s = t_s >>> SHIFT;
    pcm = s_s[OUT_W-1:0];
    clip_f = 1'b0;
    if (s_s > SMAX) begin
      pcm = PCM_MAX;
      clip_f = 1'b1;
    end else if (s_s < SMIN) begin
      pcm = PCM_MIN;
      clip_f = 1'b1;
    end
  end

  // ---------------- state ----------------
  logic [0:0]       state_q, state_d;
  logic [OUT_W-1:0] hold_q, hold_d;
  logic [OUT_W-1:0] shift_q, shift_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             dat_q, dat_d;
  logic             busy_q, busy_d;
  logic             clip_q, clip_d;
  logic [15:0]      ccnt_q, ccnt_d;

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    dat_d   = dat_q;
    busy_d  = busy_q;
    clip_d  = 1'b0;
    ccnt_d  = ccnt_q;
    if (!i_valid) begin
      state_d = S_IDLE;
      hold_d  = '0;
      shift_d = '0;
      cnt_d   = '0;
      dat_d   = 1'b0;
      busy_d  = 1'b0;
    end else if (lrclk_negedge) begin
      // Left word: capture a fresh sample. The IIR updates on the
      // lrclk rising edge, so audio_in is stable here.
      hold_d  = pcm;
      shift_d = pcm;
      clip_d  = clip_f;
      if (clip_f && ccnt_q != 16'hFFFF)
        ccnt_d = ccnt_q + 16'd1;
      state_d = S_SHIFT;
      cnt_d   = '0;
      busy_d  = 1'b1;
    end else if (lrclk_posedge) begin
      // Right word replays the held sample.
      shift_d = hold_q;
      state_d = S_SHIFT;
      cnt_d   = '0;
      busy_d  = 1'b1;
    end else if (bclk_negedge) begin
      // A bclk strobe coincident with an lrclk strobe never gets here,
      // which gives the I2S one-bit delay before the MSB.
      unique case (state_q)
        S_SHIFT: begin
          dat_d   = shift_q[OUT_W-1];
          shift_d = shift_q << 1;
          cnt_d   = cnt_q + 1'b1;
          if (cnt_q == CW'(OUT_W - 1)) begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
          end
        end
        default: dat_d = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      hold_q  <= '0;
      shift_q <= '0;
      cnt_q   <= '0;
      dat_q   <= 1'b0;
      busy_q  <= 1'b0;
      clip_q  <= 1'b0;
      ccnt_q  <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      dat_q   <= dat_d;
      busy_q  <= busy_d;
      clip_q  <= clip_d;
      ccnt_q  <= ccnt_d;
    end
  end

  assign o_dacdat   = dat_q;
  assign o_busy     = busy_q;
  assign o_clip     = clip_q;
  assign o_clip_cnt = ccnt_q;

endmodule

// File: doc/iir_i2s_dac_out.md
Name: iir_i2s_dac_out

Overview:
- Downstream stage of the IIR filter. It takes the filter's 21-bit signed mono output and converts it to 16-bit PCM with optional arithmetic shift, rounding and saturation.
- It serializes the same sample MSB-first onto the I2S DAC data line for both left and right channels.
- It works from the same one-cycle lrclk/bclk edge strobes the rest of the audio path uses, all in the single system clock domain.
- It counts clipping events for debug display.

Parameters:
- IN_W, 21: width of the signed input sample.
- OUT_W, 16: width of the serialized PCM word.
- SHIFT, 0: arithmetic right shift applied before saturation (0..IN_W-1).
- ROUND, 0: 1 adds 2^(SHIFT-1) before shifting (round half up). Ignored when SHIFT=0.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- i_rst  in  1  synchronous, active-high reset.
- i_valid  in  1  filter path enabled; low flushes the block.
- lrclk_negedge  in  1  one-cycle strobe at each lrclk falling edge (left word start).
- lrclk_posedge  in  1  one-cycle strobe at each lrclk rising edge (right word start).
- bclk_negedge  in  1  one-cycle strobe at each bclk falling edge.
- audio_in  in  IN_W  signed sample from the IIR stage.
- o_dacdat  out  1  serial DAC data.
- o_busy  out  1  high while a word is being shifted.
- o_clip  out  1  one-cycle pulse when a latched sample saturated.
- o_clip_cnt  out  16  saturating count of clip events.

Behaviour:
- Reset: i_rst high at a clk edge clears everything. o_dacdat=0, o_busy=0, o_clip=0, o_clip_cnt=0, hold and shift registers=0, bit counter=0, FSM=IDLE.
- Reset has priority over every strobe, including mid-word.
- Conversion, combinational from audio_in:
  - t = audio_in + (ROUND && SHIFT>0 ? 2^(SHIFT-1) : 0), computed at IN_W+1 bits so the rounding add cannot overflow.
  - s = t >>> SHIFT.
  - If s > 2^(OUT_W-1)-1, output 0x7FFF and flag clip. If s < -2^(OUT_W-1), output 0x8000 and flag clip. Otherwise output s[OUT_W-1:0].
- Sample capture:
  - On lrclk_negedge: hold <= conversion; shift reg <= conversion; o_clip <= clip flag.
  - When clip is flagged, o_clip_cnt increments, sticking at 0xFFFF.
  - Capturing on the negedge keeps the sample stable, because the IIR updates its output on lrclk_posedge.
  - Latency: a sample updated at lrclk_posedge N is transmitted starting at the next lrclk_negedge.
- Right word: on lrclk_posedge, shift reg <= hold. No new capture, no clip evaluation.
- FSM states: IDLE, SHIFT.
  - Any lrclk strobe while i_valid=1 moves to SHIFT from either state, reloads the shift register, bit counter <= 0, o_busy <= 1.
  - An lrclk strobe during SHIFT aborts the current word and restarts; no error is flagged.
  - In SHIFT, each bclk_negedge drives o_dacdat <= shift[OUT_W-1-cnt] and increments cnt.
  - After bit 0 is driven (cnt reaches OUT_W), the FSM goes to IDLE and o_busy <= 0.
  - In IDLE, a bclk_negedge drives o_dacdat <= 0.
- I2S one-bit delay: a bclk_negedge in the same cycle as an lrclk strobe is ignored. The MSB goes out on the first bclk_negedge strictly after the strobe.
- Both lrclk strobes in the same cycle is illegal; if it happens, the negedge path wins.
- i_valid low at a clk edge:
  - hold, shift reg, counter <= 0; o_dacdat <= 0; o_busy <= 0; FSM=IDLE; o_clip <= 0.
  - o_clip_cnt is retained.
  - Strobes are ignored while i_valid is low.
- o_clip is high for exactly one cycle per clipped capture.

Test Plan:
1. Defaults. audio_in=0x00ABC, lrclk_negedge, then 16 bclk_negedge strobes -> o_dacdat shows 0000_1010_1011_1100 MSB-first; o_busy high for exactly those 16 strobes; idle bits are 0. Then lrclk_posedge with audio_in changed to 0x00001 -> right word is 0x0ABC again.
2. Saturation.
   - audio_in=40000 at lrclk_negedge -> word 0x7FFF, o_clip one-cycle pulse, o_clip_cnt=1.
   - audio_in=-40000 at lrclk_negedge -> word 0x8000, o_clip_cnt=2.
   - audio_in=32767 at lrclk_negedge -> 0x7FFF with no clip.
3. SHIFT=4, ROUND=1.
   - audio_in=24 -> word 0x0002.
   - audio_in=-24 -> 0xFFFF.
   - audio_in=23 -> 0x0001.
   - audio_in=0x0FFFFF -> 0x7FFF with clip.
4. Word 0xA5A5 loaded. Assert lrclk_posedge after 7 bits, coincident with a bclk_negedge -> that bclk strobe is ignored; the next bclk_negedge outputs hold[15]; the counter restarts at 0.
5. Deassert i_valid mid-word, bit 9 -> next cycle o_dacdat=0, o_busy=0, o_clip_cnt unchanged. Strobes are ignored until i_valid returns; the first capture after that transmits correctly.
6. Assert i_rst for one cycle during SHIFT, with o_clip_cnt=3 -> all outputs 0 and o_clip_cnt=0 on the next cycle. Later strobes operate normally.
